// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V core: opcodes, control FSM states and datapath mux selects.
// Pure declarations, no logic; imported by the main control, its immediate decoder and the ALU control decoder.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_JALR, S_JALRLINK,
        S_LUI, S_TRAP
    } mc_state_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/mc_main_control_imm_src_dec.sv
// Combinational opcode -> immediate-format decoder, zero latency, no flow control.
// U-format decode for LUI/AUIPC exists only when MC_UPPER_IMM_EN is defined.
module imm_src_dec
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] imm_src_o
);

    always_comb begin
        imm_src_o = IMM_I;
        case (opcode_i)
            OP_STORE:  imm_src_o = IMM_S;
            OP_BRANCH: imm_src_o = IMM_B;
            OP_JAL:    imm_src_o = IMM_J;
`ifdef MC_UPPER_IMM_EN
            OP_LUI,
            OP_AUIPC:  imm_src_o = IMM_U;
`endif
            default:   imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Moore control FSM of the multi-cycle core; 3-5 cycles per instruction, stalls in FETCH/MEMREAD/MEMWRITE on !mem_ready.
// LUI/AUIPC handling is enabled by MC_UPPER_IMM_EN; otherwise both opcodes trap.
module mc_main_control
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal
);

    mc_state_t  state_q, state_d;
    logic [2:0] imm_src_w;
    logic       pc_update;
    logic       branch;

    imm_src_dec u_imm_src_dec (
        .opcode_i  (opcode),
        .imm_src_o (imm_src_w)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        imm_src    = imm_src_w;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jump target lands in ALUOut for the following state.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JALR:           state_d = S_JALR;
`ifdef MC_UPPER_IMM_EN
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
`endif
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_RTYPE;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ITYPE;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // Link value OldPC+4 goes to ALUOut while the PC takes the target.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_update  = 1'b1;
                state_d    = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_BRANCH;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                pc_write   = 1'b1;
                state_d    = S_JALRLINK;
            end
            S_JALRLINK: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                state_d   = S_ALUWB;
            end
`ifdef MC_UPPER_IMM_EN
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = S_ALUWB;
            end
`endif
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        pc_write = pc_write | pc_update | (branch & branch_taken);

        // Reset cycle presents a fully quiet interface regardless of the old state.
        if (rst) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            imm_src    = 3'b000;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multi-cycle main control unit for the RISC-V multi-cycle core. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, and produces the 2-bit `alu_op` consumed by the existing ALU control decoder. It stalls on a memory ready handshake and traps illegal opcodes.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: `instr[6:0]` from the instruction register.
- `branch_taken` in 1: datapath branch comparison result.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: `pc_update | (branch & branch_taken)`.
- `adr_src` out 1: memory address select; 0 = PC, 1 = Result.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: latch IR and OldPC.
- `result_src` out 2: Result mux select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a` out 2: ALU A operand; 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `alu_src_b` out 2: ALU B operand; 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `alu_op` out 2: 00 = add (ld/st/jalr/auipc/jal), 01 = branch, 10 = R-type, 11 = I-type.
- `imm_src` out 3: immediate format; I = 000, S = 001, B = 010, J = 011, U = 100.
- `reg_write` out 1: register file write enable.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: sticky trap flag.

## Operation
- Unlisted outputs are 0 in every state. All outputs are a function of the state only, except `imm_src` (from `opcode`) and the `mem_ready`-gated terms below.
- `pc_update` is internal: it is 1 only in FETCH and JAL.
- FETCH
  - Drives `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `result_src`=10.
  - `ir_write` and `pc_update` are both gated by `mem_ready`.
  - Stays in FETCH while `!mem_ready`, then goes to DECODE.
- DECODE
  - Drives `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (computes the branch/jump target into ALUOut).
  - Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BRANCH
    - 1100111 → JALR
    - 0110111 / 0010111 → see Configuration
    - anything else → TRAP
- MEMADR: `alu_src_a`=10, `alu_src_b`=01. Goes to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: `adr_src`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, `instr_done`=1. Goes to FETCH.
- MEMWRITE: `adr_src`=1, `mem_write`=1, held until `mem_ready`. Asserts `instr_done` in the cycle `mem_ready` is seen, then goes to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Goes to ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=11. Goes to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, `instr_done`=1. Goes to FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `result_src`=00, `pc_update`=1. Goes to ALUWB.
- BRANCH: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, branch=1, `instr_done`=1. Goes to FETCH.
- JALR: `alu_src_a`=10, `alu_src_b`=01, `result_src`=10, `pc_write`=1. Goes to JALRLINK.
- JALRLINK: `alu_src_a`=01, `alu_src_b`=10. Goes to ALUWB.
- TRAP: all enables 0, `illegal`=1. Absorbing; only `rst` exits.
- `imm_src` decodes from `opcode`: 0100011 → S, 1100011 → B, 1101111 → J, LUI/AUIPC → U, everything else → I.

## Timing
- Reset
  - While `rst`=1, state is forced to FETCH on the edge.
  - All outputs are 0 during the reset cycle, including `ir_write`, `pc_write` and `illegal`.
  - The first fetch begins in the cycle after `rst` deasserts.
  - Reset mid-instruction abandons it with no write pulse.
- Cycles per instruction, with `mem_ready` tied high:
  - lw 5; sw 4; R 4; I 4; jal 4; jalr 5; beq 3; lui 4; auipc 3.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `pc_write`, `ir_write` and `mem_write` commit only on the cycle `mem_ready`=1. They never double-commit across a stall.
- `branch_taken` is sampled combinationally in BRANCH only.

## Configuration
- `MC_UPPER_IMM_EN` defined:
  - LUI: DECODE → LUI state (`alu_src_a`=11, `alu_src_b`=01, `alu_op`=00) → ALUWB.
  - AUIPC: DECODE → ALUWB directly, since ALUOut already holds OldPC+U-imm.
- Undefined: both opcodes go to TRAP, and `imm_src` U decode is removed.

## Structure
- `riscv_pkg` holds:
  - opcode localparams;
  - state enum (`mc_state_t`);
  - ALU-op encodings;
  - `result_src`, `alu_src_a` and `alu_src_b` encodings;
  - `imm_src` encodings.
- `ALU_control` imports the ALU-op encodings from the same package.
- Sub-module `imm_src_dec`: the combinational opcode → `imm_src` decoder.

## Test plan
- **Reset:** `rst` high 2 cycles → all outputs 0. Next cycle is FETCH with `ir_write`=1, `alu_src_b`=10.
- **lw 0x00002083, `mem_ready`=1:** states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `reg_write`=1 and `result_src`=01 in cycle 5 only; one `instr_done`.
- **sw, `mem_ready` low 3 cycles in MEMWRITE:** `mem_write` high exactly 4 cycles; `instr_done` on the 4th only.
- **beq, `branch_taken`=1 then 0:** `pc_write`=1 in BRANCH only when taken; `alu_op`=01; 3-cycle CPI.
- **R-type add then I-type addi:** `alu_op` is 10 in EXECR and 11 in EXECI; `reg_write` in ALUWB.
- **Opcode 0000000:** enters TRAP and `illegal`=1 persists 10 cycles; `rst` clears it. Repeat with 0110111 with and without `MC_UPPER_IMM_EN`: LUI path taken vs TRAP.
